// File: rtl/emu_frontend_pkg.sv
// Shared types and AXI encodings for the emulation front-end AXI master.
// EMU_FRONTEND_TIMEOUT_EN adds the DRAIN state used after a watchdog response.
package emu_frontend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_B,
    ST_RD_AR,
    ST_RD_R,
    ST_RSP
`ifdef EMU_FRONTEND_TIMEOUT_EN
    , ST_DRAIN
`endif
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B     = 3'd3;

endpackage

// File: rtl/emu_axi_frontend_master.sv
// Single-outstanding AXI4 initiator turning host cmd/rsp handshakes into single-beat transfers.
// Optional response watchdog and DRAIN state enabled by EMU_FRONTEND_TIMEOUT_EN.
module emu_axi_frontend_master
  import emu_frontend_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int ID_WIDTH       = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [3:0]              m_axi_awqos,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awuser,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [1:0]              m_axi_bresp,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic                    m_axi_buser,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [3:0]              m_axi_arqos,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_aruser,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic                    m_axi_ruser
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_e                  state_reg, state_next;
  logic                    aw_done_reg, aw_done_next;
  logic                    w_done_reg, w_done_next;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [STRB_WIDTH-1:0]   wstrb_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
  logic [1:0]              resp_reg, resp_next;
  logic                    timeout_reg, timeout_next;
  logic                    wd_expired;
  logic                    unused_ok;

  // IDs, user bits and rlast carry no information for a single-beat, single-ID master.
  assign unused_ok = ^{m_axi_bid, m_axi_buser, m_axi_rid, m_axi_ruser, m_axi_rlast};

`ifdef EMU_FRONTEND_TIMEOUT_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_WIDTH-1:0] wd_cnt_reg;
  logic                 write_reg;
  logic                 wait_state;

  assign wait_state = (state_reg == ST_WR_B) | (state_reg == ST_RD_R);
  // Count is 0 in the first waiting cycle, so the limit hits in cycle TIMEOUT_CYCLES.
  assign wd_expired = wait_state & (wd_cnt_reg == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_reg <= '0;
      write_reg  <= 1'b0;
    end else begin
      if (!wait_state) begin
        wd_cnt_reg <= '0;
      end else begin
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end
      if (cmd_valid && cmd_ready) begin
        write_reg <= cmd_write;
      end
    end
  end

  // DRAIN only listens on the channel of the abandoned transaction.
  assign m_axi_bready = (state_reg == ST_WR_B) | ((state_reg == ST_DRAIN) & write_reg);
  assign m_axi_rready = (state_reg == ST_RD_R) | ((state_reg == ST_DRAIN) & ~write_reg);
`else
  assign wd_expired   = 1'b0;
  assign m_axi_bready = (state_reg == ST_WR_B);
  assign m_axi_rready = (state_reg == ST_RD_R);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      rdata_reg   <= '0;
      resp_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      rdata_reg   <= rdata_next;
      resp_reg    <= resp_next;
      timeout_reg <= timeout_next;
      if (cmd_valid && cmd_ready) begin
        addr_reg  <= {cmd_addr[ADDR_WIDTH-1:3], 3'b000};
        wdata_reg <= cmd_wdata;
        wstrb_reg <= cmd_wstrb;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    rdata_next   = rdata_reg;
    resp_next    = resp_reg;
    timeout_next = timeout_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = cmd_write ? ST_WR_REQ : ST_RD_AR;
        end
      end
      ST_WR_REQ: begin
        if (m_axi_awvalid && m_axi_awready) aw_done_next = 1'b1;
        if (m_axi_wvalid && m_axi_wready)   w_done_next  = 1'b1;
        if (aw_done_next && w_done_next)    state_next   = ST_WR_B;
      end
      ST_WR_B: begin
        if (m_axi_bvalid) begin
          rdata_next   = '0;
          resp_next    = m_axi_bresp;
          timeout_next = 1'b0;
          state_next   = ST_RSP;
        end else if (wd_expired) begin
          rdata_next   = '0;
          resp_next    = AXI_RESP_DECERR;
          timeout_next = 1'b1;
          state_next   = ST_RSP;
        end
      end
      ST_RD_AR: begin
        if (m_axi_arready) state_next = ST_RD_R;
      end
      ST_RD_R: begin
        if (m_axi_rvalid) begin
          rdata_next   = m_axi_rdata;
          resp_next    = m_axi_rresp;
          timeout_next = 1'b0;
          state_next   = ST_RSP;
        end else if (wd_expired) begin
          rdata_next   = '0;
          resp_next    = AXI_RESP_DECERR;
          timeout_next = 1'b1;
          state_next   = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
`ifdef EMU_FRONTEND_TIMEOUT_EN
          state_next = timeout_reg ? ST_DRAIN : ST_IDLE;
`else
          state_next = ST_IDLE;
`endif
        end
      end
`ifdef EMU_FRONTEND_TIMEOUT_EN
      ST_DRAIN: begin
        if ((m_axi_bvalid && m_axi_bready) || (m_axi_rvalid && m_axi_rready)) state_next = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  assign cmd_ready     = (state_reg == ST_IDLE) & ~rst;
  assign busy          = (state_reg != ST_IDLE);
  assign rsp_valid     = (state_reg == ST_RSP);
  assign rsp_rdata     = rdata_reg;
  assign rsp_resp      = resp_reg;
  assign rsp_timeout   = timeout_reg;

  assign m_axi_awvalid = (state_reg == ST_WR_REQ) & ~aw_done_reg;
  assign m_axi_wvalid  = (state_reg == ST_WR_REQ) & ~w_done_reg;
  assign m_axi_arvalid = (state_reg == ST_RD_AR);
  assign m_axi_awaddr  = addr_reg;
  assign m_axi_araddr  = addr_reg;
  assign m_axi_wdata   = wdata_reg;
  assign m_axi_wstrb   = wstrb_reg;
  assign m_axi_wlast   = 1'b1;

  assign m_axi_awid    = '0;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = AXI_SIZE_8B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awuser  = 1'b0;
  assign m_axi_arid    = '0;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = AXI_SIZE_8B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_aruser  = 1'b0;

endmodule

// File: tb/tb_emu_axi_frontend_master.sv
// Self-checking bench: delay-configurable AXI slave model plus a response scoreboard.
// Watchdog scenarios run only when EMU_FRONTEND_TIMEOUT_EN is defined.
module tb_emu_axi_frontend_master;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [63:0] cmd_wdata = '0;
  logic [7:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_timeout, busy;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  logic        awvalid, awready, awlock, awuser, wvalid, wready, wlast;
  logic [31:0] awaddr, araddr;
  logic [0:0]  awid, arid, bid, rid;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  awcache, awqos, arcache, arqos;
  logic [63:0] wdata, rdata;
  logic        bvalid, bready, buser, arvalid, arready, arlock, aruser;
  logic        rvalid, rready, rlast, ruser;

  typedef struct packed {
    logic [63:0] rdata;
    logic [1:0]  resp;
    logic        timeout;
  } rsp_t;

  rsp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Slave knobs and observations
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [63:0] r_data_cfg = '0;
  int          b_hs = 0, r_hs = 0;
  logic [31:0] seen_awaddr = '0, seen_araddr = '0;
  logic [63:0] seen_wdata = '0;
  logic [7:0]  seen_wstrb = '0;

  emu_axi_frontend_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_awid(awid), .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
    .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awqos(awqos),
    .m_axi_awprot(awprot), .m_axi_awuser(awuser),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_bid(bid), .m_axi_buser(buser),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
    .m_axi_arid(arid), .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
    .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arqos(arqos),
    .m_axi_arprot(arprot), .m_axi_aruser(aruser),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rid(rid), .m_axi_ruser(ruser)
  );

  // AXI slave model: all inputs change on the falling edge.
  initial begin : slave
    int  aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit  aw_got, w_got, b_pend, r_pend, b_fire, r_fire;
    {awready, wready, bvalid, arready, rvalid, rlast, buser, ruser} = '0;
    bresp = '0; rresp = '0; rdata = '0; bid = '0; rid = '0;
    {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
    {aw_got, w_got, b_pend, r_pend, b_fire, r_fire} = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        {awready, wready, bvalid, arready, rvalid, rlast} = '0;
        {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
        {aw_got, w_got, b_pend, r_pend, b_fire, r_fire} = '0;
      end else begin
        if (b_fire) begin bvalid = 1'b0; b_fire = 1'b0; end
        if (r_fire) begin rvalid = 1'b0; rlast = 1'b0; r_fire = 1'b0; end
        if (b_pend) begin
          if (b_cnt >= b_delay) begin bvalid = 1'b1; bresp = b_resp_cfg; b_pend = 1'b0; end
          else b_cnt++;
        end
        if (r_pend) begin
          if (r_cnt >= r_delay) begin
            rvalid = 1'b1; rlast = 1'b1; rdata = r_data_cfg; rresp = r_resp_cfg; r_pend = 1'b0;
          end else r_cnt++;
        end
        if (bvalid && bready) begin b_fire = 1'b1; b_hs++; end
        if (rvalid && rready) begin r_fire = 1'b1; r_hs++; end
        awready = 1'b0;
        if (awvalid && !aw_got) begin
          if (aw_cnt >= aw_delay) begin awready = 1'b1; aw_got = 1'b1; aw_cnt = 0; seen_awaddr = awaddr; end
          else aw_cnt++;
        end
        wready = 1'b0;
        if (wvalid && !w_got) begin
          if (w_cnt >= w_delay) begin
            wready = 1'b1; w_got = 1'b1; w_cnt = 0; seen_wdata = wdata; seen_wstrb = wstrb;
          end else w_cnt++;
        end
        if (aw_got && w_got) begin aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; b_cnt = 0; end
        arready = 1'b0;
        if (arvalid) begin
          if (ar_cnt >= ar_delay) begin
            arready = 1'b1; ar_cnt = 0; seen_araddr = araddr; r_pend = 1'b1; r_cnt = 0;
          end else ar_cnt++;
        end
      end
    end
  end

  // Scoreboard: every response handshake pops one expected entry.
  initial begin : monitor
    rsp_t got, exp_r;
    int   txn;
    txn = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && rsp_valid && rsp_ready) begin
        got.rdata = rsp_rdata; got.resp = rsp_resp; got.timeout = rsp_timeout;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got rdata=%h resp=%b timeout=%b want none", got.rdata, got.resp, got.timeout);
        end else begin
          exp_r = exp_q.pop_front();
          if (got !== exp_r) begin
            errors++;
            $display("FAIL rsp_txn%0d got rdata=%h resp=%b timeout=%b want rdata=%h resp=%b timeout=%b",
                     txn, got.rdata, got.resp, got.timeout, exp_r.rdata, exp_r.resp, exp_r.timeout);
          end else begin
            $display("rsp txn%0d rdata=%h resp=%b timeout=%b", txn, got.rdata, got.resp, got.timeout);
          end
        end
        txn++;
      end
    end
  end

  function automatic rsp_t mk_rsp(input logic [63:0] d, input logic [1:0] r, input logic t);
    rsp_t x;
    x.rdata = d; x.resp = r; x.timeout = t;
    return x;
  endfunction

  task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept got cmd_ready=%b want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle got cmd_ready=%b want 1", tag, cmd_ready);
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, busy, awvalid, wvalid, bready, arvalid, rready, rsp_timeout} !== 9'b0 ||
        rsp_rdata !== 64'h0 || rsp_resp !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs got cmd_ready=%b rsp_valid=%b busy=%b valids=%b%b%b readies=%b%b rdata=%h resp=%b want all 0",
               cmd_ready, rsp_valid, busy, awvalid, wvalid, arvalid, bready, rready, rsp_rdata, rsp_resp);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release got cmd_ready=%b want 1", cmd_ready); end
  endtask

  task automatic test_single_write;
    rsp_ready = 1'b1; b_resp_cfg = 2'b00;
    exp_q.push_back(mk_rsp(64'h0, 2'b00, 1'b0));
    send_cmd(1'b1, 32'h1000_0000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    checks++;  // T1
    if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h1000_0000 || wlast !== 1'b1 ||
        wdata !== 64'hDEAD_BEEF_CAFE_F00D || wstrb !== 8'hFF || awlen !== 8'd0 ||
        awsize !== 3'd3 || awburst !== 2'b01) begin
      errors++;
      $display("FAIL wr_t1_bus got awvalid=%b wvalid=%b awaddr=%h wlast=%b len=%0d size=%0d burst=%b want 1 1 10000000 1 0 3 01",
               awvalid, wvalid, awaddr, wlast, awlen, awsize, awburst);
    end
    @(negedge clk);  // T2
    checks++;
    if (rsp_valid !== 1'b0 || bready !== 1'b1) begin
      errors++; $display("FAIL wr_t2 got rsp_valid=%b bready=%b want 0 1", rsp_valid, bready);
    end
    @(negedge clk);  // T3
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_t3_rsp_valid got %b want 1", rsp_valid); end
    @(negedge clk);  // T4
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_t4_cmd_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_aw_delay;
    int aw_n, w_n, b0;
    bit addr_ok;
    aw_delay = 5; aw_n = 0; w_n = 0; addr_ok = 1'b1; b0 = b_hs;
    exp_q.push_back(mk_rsp(64'h0, 2'b00, 1'b0));
    send_cmd(1'b1, 32'h2000_0014, 64'h1122_3344_5566_7788, 8'h0F);
    for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) begin
      if (awvalid) begin aw_n++; if (awaddr !== 32'h2000_0010) addr_ok = 1'b0; end
      if (wvalid) w_n++;
      @(negedge clk);
    end
    checks++;
    if (aw_n != 6 || w_n != 1 || !addr_ok) begin
      errors++; $display("FAIL aw_delay_valids got aw_cycles=%0d w_cycles=%0d addr_ok=%0d want 6 1 1", aw_n, w_n, addr_ok);
    end
    wait_idle("aw_delay");
    checks++;
    if (b_hs != b0 + 1 || seen_wdata !== 64'h1122_3344_5566_7788 || seen_wstrb !== 8'h0F) begin
      errors++; $display("FAIL aw_delay_b got b_handshakes=%0d wdata=%h wstrb=%h want 1 1122334455667788 0f",
                         b_hs - b0, seen_wdata, seen_wstrb);
    end
    aw_delay = 0;
  endtask

  task automatic test_read;
    int rr_n, r0;
    bit overlap;
    rr_n = 0; overlap = 1'b0; r0 = r_hs;
    r_data_cfg = 64'h0123_4567_89AB_CDEF; r_resp_cfg = 2'b10;
    exp_q.push_back(mk_rsp(64'h0123_4567_89AB_CDEF, 2'b10, 1'b0));
    send_cmd(1'b0, 32'h8000_000B, 64'h0, 8'h0);
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h8000_0008 || rready !== 1'b0) begin
      errors++; $display("FAIL rd_ar got arvalid=%b araddr=%h rready=%b want 1 80000008 0", arvalid, araddr, rready);
    end
    for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) begin
      if (rready) rr_n++;
      if (rready && arvalid) overlap = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (rr_n != 1 || overlap || rready !== 1'b0) begin
      errors++; $display("FAIL rd_rready got rready_cycles=%0d overlap=%0d rready_in_rsp=%b want 1 0 0", rr_n, overlap, rready);
    end
    wait_idle("read");
    checks++;
    if (r_hs != r0 + 1) begin errors++; $display("FAIL rd_handshakes got %0d want 1", r_hs - r0); end
  endtask

  task automatic test_rsp_backpressure;
    int bad;
    bit seen;
    bad = 0; seen = 1'b0;
    rsp_ready = 1'b0; r_data_cfg = 64'hA5A5_0000_FFFF_1234; r_resp_cfg = 2'b00;
    exp_q.push_back(mk_rsp(64'hA5A5_0000_FFFF_1234, 2'b00, 1'b0));
    send_cmd(1'b0, 32'h4000_0000, 64'h0, 8'h0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h5000_0000;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (rsp_valid === 1'b1);
    end
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hA5A5_0000_FFFF_1234 || rsp_resp !== 2'b00 ||
          cmd_ready !== 1'b0 || awvalid !== 1'b0 || arvalid !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (!seen || bad != 0) begin
      errors++; $display("FAIL rsp_hold got seen=%0d unstable_cycles=%0d want 1 0", seen, bad);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle("backpressure");
  endtask

  task automatic test_reset_mid_read;
    bit in_rd;
    in_rd = 1'b0;
    r_delay = 100;
    send_cmd(1'b0, 32'h3000_0000, 64'h0, 8'h0);
    for (int i = 0; i < 20 && !in_rd; i++) begin @(negedge clk); in_rd = (rready === 1'b1); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!in_rd || arvalid !== 1'b0 || rready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL rst_async got in_rd=%0d arvalid=%b rready=%b rsp_valid=%b busy=%b cmd_ready=%b want 1 0 0 0 0 0",
                         in_rd, arvalid, rready, rsp_valid, busy, cmd_ready);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0; r_delay = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release got cmd_ready=%b want 1", cmd_ready); end
  endtask

  task automatic test_back_to_back;
    bit          wr;
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  s;
    for (int k = 0; k < 6; k++) begin
      wr = k[0]; a = $urandom; d = {$urandom, $urandom}; s = 8'($urandom);
      if (wr) begin
        b_resp_cfg = 2'($urandom_range(0, 3));
        exp_q.push_back(mk_rsp(64'h0, b_resp_cfg, 1'b0));
      end else begin
        r_data_cfg = {$urandom, $urandom}; r_resp_cfg = 2'($urandom_range(0, 3));
        exp_q.push_back(mk_rsp(r_data_cfg, r_resp_cfg, 1'b0));
      end
      send_cmd(wr, a, d, s);
      checks++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
        errors++; $display("FAIL b2b_busy%0d got busy=%b cmd_ready=%b want 1 0", k, busy, cmd_ready);
      end
      wait_idle("b2b");
      checks++;
      if (wr && (seen_awaddr !== {a[31:3], 3'b000} || seen_wdata !== d || seen_wstrb !== s)) begin
        errors++; $display("FAIL b2b_wr%0d got addr=%h data=%h strb=%h want %h %h %h",
                           k, seen_awaddr, seen_wdata, seen_wstrb, {a[31:3], 3'b000}, d, s);
      end else if (!wr && seen_araddr !== {a[31:3], 3'b000}) begin
        errors++; $display("FAIL b2b_rd%0d got araddr=%h want %h", k, seen_araddr, {a[31:3], 3'b000});
      end
    end
  endtask

  task automatic test_timeout;
`ifdef EMU_FRONTEND_TIMEOUT_EN
    int n, b0;
    bit drained;
    // bvalid in the limit cycle itself must win over the watchdog
    b_delay = TO - 1; b_resp_cfg = 2'b01;
    exp_q.push_back(mk_rsp(64'h0, 2'b01, 1'b0));
    send_cmd(1'b1, 32'h6000_0000, 64'h1, 8'h01);
    wait_idle("limit_race");
    b_delay = 30; n = 0; drained = 1'b0;
    exp_q.push_back(mk_rsp(64'h0, 2'b11, 1'b1));
    send_cmd(1'b1, 32'h6000_0008, 64'h2, 8'h02);
    b0 = b_hs;
    for (int i = 0; i < 60 && rsp_valid !== 1'b1; i++) begin
      if (bready) n++;
      @(negedge clk);
    end
    checks++;
    if (n != TO || rsp_resp !== 2'b11 || rsp_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_rsp got wait_cycles=%0d resp=%b timeout=%b want %0d 11 1", n, rsp_resp, rsp_timeout, TO);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || bready !== 1'b1) begin
      errors++; $display("FAIL drain_state got cmd_ready=%b bready=%b want 0 1", cmd_ready, bready);
    end
    for (int i = 0; i < 60 && cmd_ready !== 1'b1; i++) @(negedge clk);
    drained = (b_hs == b0 + 1);
    checks++;
    if (cmd_ready !== 1'b1 || !drained) begin
      errors++; $display("FAIL drain_exit got cmd_ready=%b late_b_drained=%0d want 1 1", cmd_ready, drained);
    end
    b_delay = 0;
`else
    checks++;
    if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL timeout_tied got %b want 0", rsp_timeout); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_aw_delay();
    test_read();
    test_rsp_backpressure();
    test_reset_mid_read();
    test_back_to_back();
    test_timeout();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
